// File: rtl/mux_scan_nx1.sv
// Registered N:1 channel multiplexer with a manual-select mode and a round-robin
// auto-scan mode over a per-channel enable mask, presented on a valid/ready output.
module mux_scan_nx1 #(
  parameter int N = 16,
  parameter int W = 8,
  localparam int SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           enable,
  input  logic           mode,
  input  logic [SW-1:0]  sel,
  input  logic [N-1:0]   ch_mask,
  input  logic [N*W-1:0] a,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_ch,
  output logic           out_valid,
  input  logic           out_ready
);

  localparam logic [SW:0]   N_EXT = (SW+1)'(N);
  localparam logic [SW-1:0] LAST  = SW'(N - 1);

  // Handshake: a beat transfers on any edge where out_valid & out_ready. While
  // out_valid is high and out_ready low, out_data/out_ch/out_valid hold bit-stable;
  // a new beat loads whenever the register is empty or being drained this edge.
  logic ld;
  assign ld = enable & (~out_valid | out_ready);

  logic [W-1:0] ch_data [N];
  for (genvar g = 0; g < N; g++) begin : g_unpack
    assign ch_data[g] = a[g*W +: W];
  end

  // An out-of-range sel only exists when N is not a power of two.
  logic sel_ok;
  if ((1 << SW) == N) begin : g_sel_pow2
    assign sel_ok = 1'b1;
  end else begin : g_sel_npow2
    assign sel_ok = ({1'b0, sel} < N_EXT);
  end

  logic [SW-1:0] ptr;
  logic [SW:0]   cand;
  logic          scan_hit;
  logic [SW-1:0] scan_idx;
  logic [SW-1:0] scan_next;

  // Priority-encode the mask rotated to start at ptr. Walking the offsets from
  // high to low lets the smallest circular offset overwrite the others.
  always_comb begin
    scan_hit = 1'b0;
    scan_idx = '0;
    cand     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = {1'b0, ptr} + (SW+1)'(k);
      if (cand >= N_EXT) cand = cand - N_EXT;
      if (ch_mask[cand[SW-1:0]]) begin
        scan_hit = 1'b1;
        scan_idx = cand[SW-1:0];
      end
    end
  end

  assign scan_next = (scan_idx == LAST) ? '0 : scan_idx + SW'(1);

  logic [SW-1:0] pick_idx;
  logic          pick_ok;
  logic [W-1:0]  pick_data;

  always_comb begin
    pick_idx  = mode ? scan_idx : sel;
    pick_ok   = mode ? scan_hit : sel_ok;
    pick_data = pick_ok ? ch_data[pick_idx] : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
      ptr       <= '0;
    end else if (!enable) begin
      // Flush drops any pending beat; the scan position is kept for re-enable.
      out_data  <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
    end else begin
      if (!mode) ptr <= '0;
      if (ld) begin
        out_valid <= pick_ok;
        out_data  <= pick_data;
        out_ch    <= pick_ok ? pick_idx : '0;
        if (mode && scan_hit) ptr <= scan_next;
      end
    end
  end

endmodule
